// File: rtl/pwm_compare_if.sv
// Duty-update handshake between a duty source (master) and pwm_compare (slave).
interface pwm_compare_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_compare.sv
// Registered PWM from an upstream free-running count; duty updates are shadowed until wrap.
// Optional wrap counter on period_cnt is enabled with `define PWM_COMPARE_PERIOD_CNT_EN.
module pwm_compare #(
  parameter int unsigned    WIDTH    = 4,
  parameter logic [WIDTH:0] DUTY_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  pwm_compare_if.slave     duty_if,
  output logic             pwm_out,
  output logic             period_start,
  output logic [7:0]       period_cnt
);

  localparam logic [WIDTH:0] MaxDuty = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic [WIDTH:0]   active_duty_q, active_duty_d;
  logic [WIDTH:0]   pending_duty_q, pending_duty_d;
  logic [WIDTH:0]   duty_used;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             wrap;

  // Only a genuine all-ones -> 0 step counts; stalls and jumps never wrap.
  assign wrap               = (prev_count_q == '1) && (count == '0);
  assign duty_if.duty_ready = (state_q == StIdle);

  always_comb begin
    state_d        = state_q;
    active_duty_d  = active_duty_q;
    pending_duty_d = pending_duty_q;
    unique case (state_q)
      StIdle: begin
        if (duty_if.duty_valid) begin
          pending_duty_d = (duty_if.duty_in > MaxDuty) ? MaxDuty : duty_if.duty_in;
          state_d        = StPending;
        end
      end
      StPending: begin
        if (wrap) begin
          active_duty_d = pending_duty_q;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The wrap cycle already belongs to the new period, so it compares against the new duty.
  always_comb begin
    duty_used      = (wrap && (state_q == StPending)) ? pending_duty_q : active_duty_q;
    pwm_d          = ({1'b0, count} < duty_used);
    period_start_d = wrap;
    prev_count_d   = count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      prev_count_q   <= '0;
      active_duty_q  <= DUTY_RST;
      pending_duty_q <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= prev_count_d;
      active_duty_q  <= active_duty_d;
      pending_duty_q <= pending_duty_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

`ifdef PWM_COMPARE_PERIOD_CNT_EN
  logic [7:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (wrap) period_cnt_d = period_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) period_cnt_q <= '0;
    else      period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`else
  assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: scripted duty table, corner sequences, random stimulus.
module tb_pwm_compare;
  localparam int unsigned W   = 4;
  localparam int          Per = 1 << W;
`ifdef PWM_COMPARE_PERIOD_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] count = '0;
  logic         pwm_out, period_start;
  logic [7:0]   period_cnt;

  pwm_compare_if #(.WIDTH(W)) duty_if ();

  pwm_compare #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .duty_if      (duty_if),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .period_cnt   (period_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hi_acc, ps_acc;

  // Reference state: what the shadowed-duty rules say, one entry per concept.
  int m_prev, m_active, m_pend_val, m_pcnt, m_pwm, m_ps;
  bit m_pend;

  typedef struct {
    int duty;
    int exp_high;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_active = 0; m_pend = 1'b0; m_pend_val = 0;
    m_pcnt = 0; m_pwm = 0; m_ps = 0;
  endtask

  task automatic tick();
    bit wrap;
    int used;
    int c;
    c = int'(count);
    check("ready", int'(duty_if.duty_ready), int'(!m_pend));
    wrap  = (m_prev == Per - 1) && (c == 0);
    used  = (wrap && m_pend) ? m_pend_val : m_active;
    m_pwm = (c < used) ? 1 : 0;
    m_ps  = wrap ? 1 : 0;
    if (wrap) m_pcnt = (m_pcnt + 1) % 256;
    if (m_pend && wrap) begin
      m_active = m_pend_val;
      m_pend   = 1'b0;
    end else if (!m_pend && duty_if.duty_valid) begin
      m_pend     = 1'b1;
      m_pend_val = (int'(duty_if.duty_in) > Per) ? Per : int'(duty_if.duty_in);
    end
    m_prev = c;
    @(posedge clk);
    #1;
    check("pwm_out", int'(pwm_out), m_pwm);
    check("period_start", int'(period_start), m_ps);
    check("period_cnt", int'(period_cnt), CntEn ? m_pcnt : 0);
    hi_acc += int'(pwm_out);
    ps_acc += int'(period_start);
  endtask

  task automatic adv();
    count = count + 4'd1;
    tick();
  endtask

  initial begin
    duty_if.duty_in    = '0;
    duty_if.duty_valid = 1'b0;
    vecs[0] = '{duty: 0,  exp_high: 0};
    vecs[1] = '{duty: 16, exp_high: 16};
    vecs[2] = '{duty: 20, exp_high: 16};
    vecs[3] = '{duty: 1,  exp_high: 1};
    vecs[4] = '{duty: 15, exp_high: 15};
    vecs[5] = '{duty: 8,  exp_high: 8};
    vecs[6] = '{duty: 4,  exp_high: 4};
    model_reset();

    #12;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ready", int'(duty_if.duty_ready), 1);
    check("rst_period_start", int'(period_start), 0);
    check("rst_period_cnt", int'(period_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    // Default duty: no handshake for 64 cycles.
    tick();
    hi_acc = 0; ps_acc = 0;
    repeat (64) adv();
    check("default_high", hi_acc, 0);
    check("default_wraps", ps_acc, 4);
    check("default_period_cnt", int'(period_cnt), CntEn ? 4 : 0);

    // Duty table: accept mid-period, measure the first full period after the wrap.
    for (int i = 0; i < 7; i++) begin
      adv(); adv();
      duty_if.duty_in    = 5'(vecs[i].duty);
      duty_if.duty_valid = 1'b1;
      adv();
      duty_if.duty_valid = 1'b0;
      check("ready_after_accept", int'(duty_if.duty_ready), 0);
      while (count != '1) adv();
      hi_acc = 0; ps_acc = 0;
      repeat (Per) adv();
      check("table_high", hi_acc, vecs[i].exp_high);
      check("table_wraps", ps_acc, 1);
    end

    // Mid-period handshake with active duty 4; second offer while not ready is dropped.
    while (count != 4'd4) adv();
    duty_if.duty_in    = 5'd8;
    duty_if.duty_valid = 1'b1;
    adv();
    duty_if.duty_in = 5'd12;
    hi_acc = 0;
    while (count != '1) adv();
    check("mid_remainder_high", hi_acc, 0);
    check("mid_ready_low", int'(duty_if.duty_ready), 0);
    duty_if.duty_valid = 1'b0;
    hi_acc = 0;
    repeat (Per) adv();
    check("mid_next_high", hi_acc, 8);
    check("mid_ready_back", int'(duty_if.duty_ready), 1);

    // Acceptance on the wrap cycle itself waits a further period.
    duty_if.duty_in    = 5'd12;
    duty_if.duty_valid = 1'b1;
    hi_acc = 0;
    adv();
    duty_if.duty_valid = 1'b0;
    check("wrapacc_start", int'(period_start), 1);
    repeat (Per - 1) adv();
    check("wrapacc_old_high", hi_acc, 8);
    hi_acc = 0;
    repeat (Per) adv();
    check("wrapacc_new_high", hi_acc, 12);

    // Discontinuous jump to 0 is not a wrap.
    count = 4'd7; tick();
    count = 4'd0; tick();
    check("jump_no_wrap", int'(period_start), 0);

    // Reset with a pending update discards it.
    adv(); adv();
    duty_if.duty_in    = 5'd16;
    duty_if.duty_valid = 1'b1;
    adv();
    duty_if.duty_valid = 1'b0;
    adv(); adv();
    rst = 1'b0;
    #2;
    check("rstpend_pwm", int'(pwm_out), 0);
    check("rstpend_ready", int'(duty_if.duty_ready), 1);
    check("rstpend_period_cnt", int'(period_cnt), 0);
    count = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    hi_acc = 0;
    repeat (2 * Per) adv();
    check("rstpend_high", hi_acc, 0);

    // Random count motion (steps, stalls, jumps) and random handshakes.
    repeat (800) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       count = count + 4'd1;
      else if (r == 8) count = 4'($urandom);
      duty_if.duty_valid = ($urandom_range(0, 3) == 0);
      duty_if.duty_in    = 5'($urandom_range(0, 31));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
